// File: rtl/add_sub_pkg.sv
// add_sub_pkg: shared opcodes, flag bundle and carry-in mapping for the add/sub pipeline
package add_sub_pkg;
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;
   typedef struct packed {
      logic cout;
      logic ovf;
      logic zero;
   } flags_t;
   function automatic logic map_cin(input logic op, input logic cin);
      return (op == OP_SUB) ? ~cin : cin;
   endfunction
endpackage

// File: rtl/add_sub_pipe_if.sv
// add_sub_pipe_if: operand/result valid-ready bundle of the add/sub pipeline
interface add_sub_pipe_if #(parameter int WIDTH = 16);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             in_op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_ovf;
   logic             out_zero;
   modport master (
      output in_valid, in_a, in_b, in_cin, in_op, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
   );
   modport slave (
      input  in_valid, in_a, in_b, in_cin, in_op, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
   );
endinterface

// File: rtl/add_sub_stage.sv
// add_sub_stage: CW-bit ripple chunk with registered sum, carry and valid
module add_sub_stage #(parameter int CW = 4) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_en,
   input  logic          i_valid,
   input  logic [CW-1:0] i_a,
   input  logic [CW-1:0] i_b,
   input  logic          i_c,
   output logic          o_valid,
   output logic [CW-1:0] o_sum,
   output logic          o_cout
);
   logic [CW:0]   w_c;
   logic [CW-1:0] w_s;
   logic          r_valid;
   logic          r_cout;
   logic [CW-1:0] r_sum;
   assign w_c[0] = i_c;
   for (genvar j = 0; j < CW; j++) begin : g_fa
      fulladd u_fa (
         .i_a (i_a[j]),
         .i_b (i_b[j]),
         .i_c (w_c[j]),
         .o_s (w_s[j]),
         .o_c (w_c[j+1])
      );
   end
   // capture the chunk result and hand the carry to the next stage when the pipe advances
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
      end else if (i_en) begin
         r_valid <= i_valid;
         r_sum   <= w_s;
         r_cout  <= w_c[CW];
      end
   end
   assign o_valid = r_valid;
   assign o_sum   = r_sum;
   assign o_cout  = r_cout;
endmodule

// File: rtl/fulladd.sv
// fulladd: one-bit full adder cell
module fulladd (
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   output logic o_s,
   output logic o_c
);
   assign o_s = i_a ^ i_b ^ i_c;
   assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

// File: rtl/add_sub_pipe.sv
// add_sub_pipe: pipelined WIDTH-bit adder/subtractor, one ripple chunk per stage
module add_sub_pipe
   import add_sub_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input logic           clk,
   input logic           rst,
   add_sub_pipe_if.slave io_bus
);
   localparam int CW = WIDTH / STAGES;
   logic             w_en;
   logic [WIDTH-1:0] w_b_map;
   logic [CW-1:0]    w_ac  [STAGES];
   logic [CW-1:0]    w_bc  [STAGES];
   logic [CW-1:0]    w_sum [STAGES];
   logic [STAGES:0]  w_c;
   logic [STAGES:0]  w_v;
   logic [WIDTH-1:0] w_res;
   logic             r_axb;
   flags_t           w_flg;
   if (WIDTH % STAGES != 0) begin : g_chk
      $error("add_sub_pipe: WIDTH must be a multiple of STAGES");
   end
   assign w_en    = !(w_v[STAGES] && !io_bus.out_ready);
   assign w_b_map = (io_bus.in_op == OP_SUB) ? ~io_bus.in_b : io_bus.in_b;
   assign w_c[0]  = map_cin(io_bus.in_op, io_bus.in_cin);
   assign w_v[0]  = io_bus.in_valid;
   for (genvar k = 0; k < STAGES; k++) begin : g_st
      if (k == 0) begin : g_direct
         assign w_ac[k] = io_bus.in_a[CW-1:0];
         assign w_bc[k] = w_b_map[CW-1:0];
      end else begin : g_skew
         logic [CW-1:0] r_a [k];
         logic [CW-1:0] r_b [k];
         // delay operand chunk k by k beats so it meets the carry from stage k-1
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < k; i++) begin
                  r_a[i] <= '0;
                  r_b[i] <= '0;
               end
            end else if (w_en) begin
               r_a[0] <= io_bus.in_a[k*CW +: CW];
               r_b[0] <= w_b_map[k*CW +: CW];
               for (int i = 1; i < k; i++) begin
                  r_a[i] <= r_a[i-1];
                  r_b[i] <= r_b[i-1];
               end
            end
         end
         assign w_ac[k] = r_a[k-1];
         assign w_bc[k] = r_b[k-1];
      end
      add_sub_stage #(.CW(CW)) u_stage (
         .clk     (clk),
         .rst     (rst),
         .i_en    (w_en),
         .i_valid (w_v[k]),
         .i_a     (w_ac[k]),
         .i_b     (w_bc[k]),
         .i_c     (w_c[k]),
         .o_valid (w_v[k+1]),
         .o_sum   (w_sum[k]),
         .o_cout  (w_c[k+1])
      );
      if (k == STAGES - 1) begin : g_top
         assign w_res[k*CW +: CW] = w_sum[k];
      end else begin : g_deskew
         localparam int D = STAGES - 1 - k;
         logic [CW-1:0] r_d [D];
         // hold the early sum chunk until the top chunk catches up
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < D; i++) r_d[i] <= '0;
            end else if (w_en) begin
               r_d[0] <= w_sum[k];
               for (int i = 1; i < D; i++) r_d[i] <= r_d[i-1];
            end
         end
         assign w_res[k*CW +: CW] = r_d[D-1];
      end
   end
   // keep a^b' of the operand MSBs alongside the top stage to recover the carry into the MSB
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_axb <= 1'b0;
      else if (w_en) r_axb <= w_ac[STAGES-1][CW-1] ^ w_bc[STAGES-1][CW-1];
   end
   // flags from the full result; zero is qualified by valid so idle outputs read 0
   always_comb begin
      w_flg.cout = w_c[STAGES];
      w_flg.ovf  = r_axb ^ w_res[WIDTH-1] ^ w_c[STAGES];
      w_flg.zero = w_v[STAGES] && (w_res == '0);
   end
   assign io_bus.in_ready  = w_en;
   assign io_bus.out_valid = w_v[STAGES];
   assign io_bus.out_sum   = w_res;
   assign io_bus.out_cout  = w_flg.cout;
   assign io_bus.out_ovf   = w_flg.ovf;
   assign io_bus.out_zero  = w_flg.zero;
endmodule

// File: tb/tb_add_sub_pipe.sv
// tb_add_sub_pipe: directed and random checks of add_sub_pipe against an arithmetic model
module tb_add_sub_pipe;
   import add_sub_pkg::*;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          n_assert = 0;
   int          n_fail = 0;
   int          n_rx = 0;
   logic [18:0] q [$];
   add_sub_pipe_if #(.WIDTH(16)) bus ();
   add_sub_pipe #(.WIDTH(16), .STAGES(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
   );
   always #5 clk = ~clk;
   function automatic logic [18:0] model(logic [15:0] a, logic [15:0] b, logic cin, logic op);
      int ua, ub, ci, sr;
      logic [15:0] s;
      logic co;
      ua = int'(a);
      ub = int'(b);
      ci = int'(cin);
      if (op == OP_ADD) begin
         s  = 16'(ua + ub + ci);
         co = (ua + ub + ci) > 65535;
         sr = int'($signed(a)) + int'($signed(b)) + ci;
      end else begin
         s  = 16'(ua - ub - ci);
         co = ua >= ub + ci;
         sr = int'($signed(a)) - int'($signed(b)) - ci;
      end
      return {s, co, (sr > 32767) || (sr < -32768), s == 16'h0000};
   endfunction
   function automatic logic [18:0] obs();
      return {bus.out_sum, bus.out_cout, bus.out_ovf, bus.out_zero};
   endfunction
   task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
      n_assert++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
   endtask
   task automatic rand_in();
      bus.in_a   = 16'($urandom);
      bus.in_b   = 16'($urandom);
      bus.in_cin = 1'($urandom_range(0, 1));
      bus.in_op  = 1'($urandom_range(0, 1));
   endtask
   task automatic tick();
      #1;
      if (bus.out_valid && bus.out_ready) begin
         n_rx++;
         chk("queue_nonempty", q.size() > 0, 1);
         if (q.size() > 0) chk("scoreboard", obs(), q.pop_front());
      end
      if (bus.in_valid && bus.in_ready) q.push_back(model(bus.in_a, bus.in_b, bus.in_cin, bus.in_op));
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic single(string tag, logic [15:0] a, logic [15:0] b, logic cin, logic op, logic [18:0] e);
      int lat;
      bus.in_a      = a;
      bus.in_b      = b;
      bus.in_cin    = cin;
      bus.in_op     = op;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      rand_in();
      lat = 1;
      while (!bus.out_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk({tag, "_latency"}, lat, 4);
      chk(tag, obs(), e);
      tick();
   endtask
   initial begin
      int sent, base;
      logic [19:0] snap;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_cin    = 1'b0;
      bus.in_op     = OP_ADD;
      bus.out_ready = 1'b1;
      snap          = '0;
      @(negedge clk);
      chk("reset_valid", bus.out_valid, 0);
      chk("reset_data", obs(), 0);
      rst = 1'b0;
      #1 chk("ready_after_release", bus.in_ready, 1);
      single("add_chunk_carry", 16'h00FF, 16'h0001, 1'b0, OP_ADD, {16'h0100, 3'b000});
      single("add_wrap_zero",   16'hFFFF, 16'h0000, 1'b1, OP_ADD, {16'h0000, 3'b101});
      single("add_ovf",         16'h7FFF, 16'h0001, 1'b0, OP_ADD, {16'h8000, 3'b010});
      single("sub_borrow",      16'h0005, 16'h0007, 1'b0, OP_SUB, {16'hFFFE, 3'b000});
      single("sub_ovf",         16'h8000, 16'h0001, 1'b0, OP_SUB, {16'h7FFF, 3'b110});
      single("sub_borrow_in",   16'h0003, 16'h0003, 1'b1, OP_SUB, {16'hFFFF, 3'b000});
      sent = 0;
      base = n_rx;
      for (int i = 0; i < 60 && n_rx - base < 8; i++) begin
         rand_in();
         bus.in_valid  = sent < 8;
         bus.out_ready = !(i >= 5 && i < 8);
         #1;
         if (!bus.out_ready) begin
            chk("stall_in_ready", bus.in_ready, 0);
            if (i == 5) snap = {bus.out_valid, obs()};
            else chk("stall_hold", {bus.out_valid, obs()}, snap);
         end
         if (bus.in_valid && bus.in_ready) sent++;
         tick();
      end
      chk("stream_count", n_rx - base, 8);
      chk("stream_drained", q.size(), 0);
      for (int i = 0; i < 40; i++) begin
         rand_in();
         bus.in_valid  = 1'($urandom_range(0, 1));
         bus.out_ready = $urandom_range(0, 3) != 0;
         #1 chk("ready_rule", bus.in_ready, !(bus.out_valid && !bus.out_ready));
         tick();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      chk("random_drained", q.size(), 0);
      for (int i = 0; i < 4; i++) begin
         rand_in();
         bus.in_valid = 1'b1;
         tick();
      end
      bus.in_valid = 1'b0;
      chk("pre_reset_valid", bus.out_valid, 1);
      rst = 1'b1;
      #1;
      chk("reset_async_valid", bus.out_valid, 0);
      chk("reset_async_data", obs(), 0);
      q.delete();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("ready_after_reset", bus.in_ready, 1);
      single("after_reset", 16'h1234, 16'h1111, 1'b0, OP_ADD, {16'h2345, 3'b000});
      for (int i = 0; i < 6; i++) tick();
      chk("final_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
